// File: rtl/div_iter_param.sv
// Iterative restoring divider: WIDTH-bit operands, runtime signed/unsigned mode,
// BITS_PER_CYCLE quotient bits per clock, quotient/remainder with C semantics.
module div_iter_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data_dividend,
  input  logic [WIDTH-1:0] data_divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH:0]          acc;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH-1:0]        mag_m;
  logic                    qneg;
  logic                    rneg;

  logic signed [WIDTH-1:0] dividend_s;
  logic signed [WIDTH-1:0] divisor_s;
  logic                    start_ok;
  logic                    div_zero;
  logic                    sgn_ovf;
  logic [2*WIDTH:0]        step_res;

  // Absolute value in signed mode; unsigned operands pass through untouched.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // BITS_PER_CYCLE chained restoring steps; the partial remainder keeps one
  // extra bit so the trial subtraction's sign is never lost.
  function automatic logic [2*WIDTH:0] restore_steps(input logic [WIDTH:0]   a,
                                                     input logic [WIDTH-1:0] q,
                                                     input logic [WIDTH-1:0] m);
    logic [WIDTH:0]   aa;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] qq;
    aa = a;
    qq = q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      aa = {aa[WIDTH-1:0], qq[WIDTH-1]};
      qq = {qq[WIDTH-2:0], 1'b0};
      t  = aa - {1'b0, m};
      if (!t[WIDTH]) begin
        aa    = t;
        qq[0] = 1'b1;
      end
    end
    return {aa, qq};
  endfunction

  assign dividend_s = data_dividend;
  assign divisor_s  = data_divisor;
  assign start_ok   = ctrl_div && (state == IDLE || state == DONE);
  assign div_zero   = (data_divisor == '0);
  assign sgn_ovf    = is_signed && (dividend_s == $signed(MIN_VAL)) &&
                      (divisor_s == -1);
  assign step_res   = restore_steps(acc, quo, mag_m);

  // Control and result registers
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      exception <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (ctrl_div) begin
            if (div_zero) begin
              state     <= DONE;
              exception <= 1'b1;
              quotient  <= '0;
              remainder <= data_dividend;
              ready     <= 1'b1;
            end else if (sgn_ovf) begin
              state     <= DONE;
              exception <= 1'b1;
              quotient  <= MIN_VAL;
              remainder <= '0;
              ready     <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= qneg ? -quo : quo;
          remainder <= rneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          exception <= 1'b0;
          ready     <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand capture at start, then one step block per RUN cycle
  always_ff @(posedge clock) begin
    if (start_ok) begin
      acc   <= '0;
      quo   <= magnitude(data_dividend, is_signed);
      mag_m <= magnitude(data_divisor, is_signed);
      qneg  <= is_signed && (data_dividend[WIDTH-1] ^ data_divisor[WIDTH-1]);
      rneg  <= is_signed && data_dividend[WIDTH-1];
    end else if (state == RUN) begin
      {acc, quo} <= step_res;
    end
  end

endmodule

// File: tb/tb_div_iter_param.sv
// Bench for div_iter_param: one BPC=1 and one BPC=2 instance against a
// cycle-level reference model of C-style division plus directed literal checks.
module tb_div_iter_param;

  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        div_r [2];
  logic        sgn_r [2];
  logic [31:0] a_r   [2];
  logic [31:0] b_r   [2];
  logic        busy_o[2];
  logic        rdy_o [2];
  logic [31:0] q_o   [2];
  logic [31:0] r_o   [2];
  logic        exc_o [2];

  int checks = 0;
  int errors = 0;

  div_iter_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut0 (
    .clock(clk), .ctrl_reset(rst), .ctrl_div(div_r[0]), .is_signed(sgn_r[0]),
    .data_dividend(a_r[0]), .data_divisor(b_r[0]), .busy(busy_o[0]),
    .ready(rdy_o[0]), .quotient(q_o[0]), .remainder(r_o[0]), .exception(exc_o[0]));

  div_iter_param #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut1 (
    .clock(clk), .ctrl_reset(rst), .ctrl_div(div_r[1]), .is_signed(sgn_r[1]),
    .data_dividend(a_r[1]), .data_divisor(b_r[1]), .busy(busy_o[1]),
    .ready(rdy_o[1]), .quotient(q_o[1]), .remainder(r_o[1]), .exception(exc_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // C semantics reference with the two exception cases taken first.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 0; r = a; e = 1'b1;
    end else if (s && a == MIN_VAL && b == 32'hFFFF_FFFF) begin
      q = MIN_VAL; r = 0; e = 1'b1;
    end else if (s) begin
      q = sa / sb; r = sa % sb; e = 1'b0;
    end else begin
      q = a / b; r = a % b; e = 1'b0;
    end
  endtask

  // Inputs as seen by each rising edge, for the model.
  bit          snap_ok = 0;
  logic        snap_rst;
  logic        snap_div[2];
  logic        snap_s  [2];
  logic [31:0] snap_a  [2];
  logic [31:0] snap_b  [2];

  always @(posedge clk) begin
    snap_rst = rst;
    for (int d = 0; d < 2; d++) begin
      snap_div[d] = div_r[d];
      snap_s[d]   = sgn_r[d];
      snap_a[d]   = a_r[d];
      snap_b[d]   = b_r[d];
    end
    snap_ok = 1;
  end

  // Model: pending result with edges left until ready; held outputs.
  bit          pend [2];
  int          left [2];
  logic [31:0] pq[2], pr[2], hq[2], hr[2];
  logic        pe[2], he[2];
  int          lat_edges[2] = '{33, 17};

  always @(negedge clk) begin
    if (snap_ok) begin
      for (int d = 0; d < 2; d++) begin
        logic        rexp;
        logic [31:0] tq, tr;
        logic        te;
        rexp = 1'b0;
        if (snap_rst) begin
          pend[d] = 0; hq[d] = 0; hr[d] = 0; he[d] = 0;
        end else if (pend[d]) begin
          left[d]--;
          if (left[d] == 0) begin
            pend[d] = 0; rexp = 1'b1;
            hq[d] = pq[d]; hr[d] = pr[d]; he[d] = pe[d];
          end
        end else if (snap_div[d]) begin
          ref_div(snap_a[d], snap_b[d], snap_s[d], tq, tr, te);
          if (te) begin
            rexp = 1'b1; hq[d] = tq; hr[d] = tr; he[d] = 1'b1;
          end else begin
            pend[d] = 1; left[d] = lat_edges[d];
            pq[d] = tq; pr[d] = tr; pe[d] = 1'b0;
          end
        end
        chk($sformatf("cyc_ready%0d", d), 32'(rdy_o[d]), 32'(rexp));
        chk($sformatf("cyc_busy%0d", d), 32'(busy_o[d]), 32'(pend[d]));
        chk($sformatf("cyc_q%0d", d), q_o[d], hq[d]);
        chk($sformatf("cyc_r%0d", d), r_o[d], hr[d]);
        chk($sformatf("cyc_exc%0d", d), 32'(exc_o[d]), 32'(he[d]));
      end
    end
  end

  task automatic start_now(input int d, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
    div_r[d] = 1'b1; a_r[d] = a; b_r[d] = b; sgn_r[d] = s;
    @(posedge clk);
    #1;
    div_r[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d, input int limit, output int cyc, output int bcyc);
    cyc = 0;
    bcyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rdy_o[d] === 1'b1) break;
      if (busy_o[d] === 1'b1) bcyc++;
      if (cyc >= limit) begin
        chk("ready_timeout", 32'(cyc), 32'(limit + 1));
        break;
      end
    end
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [31:0] eq, input logic [31:0] er,
                     input logic ee, input int elat);
    int cyc, bcyc;
    start_now(d, a, b, s);
    wait_ready(d, 60, cyc, bcyc);
    chk("latency", 32'(cyc), 32'(elat));
    chk("busy_cycles", 32'(bcyc), 32'(elat - 1));
    chk("quotient", q_o[d], eq);
    chk("remainder", r_o[d], er);
    chk("exception", 32'(exc_o[d]), 32'(ee));
  endtask

  initial begin
    int cnt_rdy;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      div_r[d] = 1'b0; sgn_r[d] = 1'b0; a_r[d] = '0; b_r[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy_o[0]), 0);
    chk("reset_ready", 32'(rdy_o[0]), 0);
    chk("reset_q", q_o[0], 0);
    chk("reset_r", r_o[0], 0);
    chk("reset_exc", 32'(exc_o[0]), 0);

    // Signed sign combinations
    run(0, 100, 7, 1'b1, 14, 2, 1'b0, 34);
    run(0, -32'sd100, 7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    run(0, 100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 2, 1'b0, 34);
    run(0, -32'sd100, -32'sd7, 1'b1, 14, 32'hFFFF_FFFE, 1'b0, 34);

    // Divide by zero, then an ordinary start
    run(0, 5, 0, 1'b0, 0, 5, 1'b1, 1);
    run(0, 9, 3, 1'b0, 3, 0, 1'b0, 34);

    // MIN / all-ones in both modes
    run(0, MIN_VAL, 32'hFFFF_FFFF, 1'b1, MIN_VAL, 0, 1'b1, 1);
    run(0, MIN_VAL, 32'hFFFF_FFFF, 1'b0, 0, MIN_VAL, 1'b0, 34);

    // Ignored start while busy, then abort with reset
    @(posedge clk);
    #1;
    start_now(0, 1000, 10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start_now(0, 7, 7, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o[0]), 0);
    chk("abort_ready", 32'(rdy_o[0]), 0);
    chk("abort_q", q_o[0], 0);
    chk("abort_r", r_o[0], 0);
    cnt_rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (rdy_o[0] === 1'b1) cnt_rdy++;
    end
    chk("abort_no_ready", 32'(cnt_rdy), 0);
    run(0, 1000, 10, 1'b0, 100, 0, 1'b0, 34);

    // Two bits per cycle, back-to-back starts on the ready cycle
    run(1, 32'hFFFF_FFFF, 3, 1'b0, 32'h5555_5555, 0, 1'b0, 18);
    run(1, -32'sd100, 7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 18);
    run(1, MIN_VAL, 32'hFFFF_FFFF, 1'b1, MIN_VAL, 0, 1'b1, 1);
    run(1, 12345, 0, 1'b1, 0, 12345, 1'b1, 1);
    run(1, 32'hFFFF_FFF9, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 18);

    // Mixed sweep on both instances
    for (int i = 0; i < 24; i++) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] a, b, eq, er;
        logic        s, ee;
        a = $urandom;
        b = $urandom;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0: b = 0;
          1: begin a = MIN_VAL; b = 32'hFFFF_FFFF; end
          2: b = 32'($urandom_range(1, 20));
          3: b = -32'($urandom_range(1, 20));
          default: ;
        endcase
        ref_div(a, b, s, eq, er, ee);
        run(d, a, b, s, eq, er, ee, ee ? 1 : (d == 0 ? 34 : 18));
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
